// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator (sync, blanking,
// display enable, pixel coordinates, line/frame strobes) with an integer
// pixel-clock divider and a run/stop control that always completes the
// current frame before parking in IDLE.
//
// Optional feature: define VGA_TIMING_FRAMECNT_EN to add the 16-bit
// frame_cnt output (counts frame_start pulses, wraps, cleared by reset only).
//
// Handshake/control: 'run' is a level. It is sampled on every clock edge.
// IDLE leaves on the first edge that sees run=1. RUN/STOP follow run
// continuously. Only STOP with run=0 at the last pixel's pix_ce parks
// the block in IDLE.
//
// All flags are registered and derived from the next-count values, so on
// any clock every output agrees with the hloc/vloc presented on that clock.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned CW       = 11
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          enable,
  output logic [CW-1:0] hloc,
  output logic [CW-1:0] vloc,
  output logic          line_start,
  output logic          frame_start,
  output logic [1:0]    dbg_state
`ifdef VGA_TIMING_FRAMECNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Reject configurations the counters cannot represent.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (((H_TOTAL - 1) >> CW) != 0) begin : g_bad_hcw
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1");
  end
  if (((V_TOTAL - 1) >> CW) != 0) begin : g_bad_vcw
    $error("vga_timing_gen: CW too narrow for V_TOTAL-1");
  end

  // Comparison constants carry one spare bit so an exclusive upper bound
  // equal to the total never overflows the coordinate width.
  localparam logic [CW:0]   H_ACT_X  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   HS_BEG_X = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_END_X = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   V_ACT_X  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   VS_BEG_X = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_END_X = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hloc_q, hloc_d;
  logic [CW-1:0] vloc_q, vloc_d;

  logic pix_ce_q, pix_ce_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic hblank_q, hblank_d;
  logic vblank_q, vblank_d;
  logic enable_q, enable_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  logic        div_last;
  logic        h_last;
  logic        v_last;
  logic        active_d;
  logic [CW:0] hx_d;
  logic [CW:0] vx_d;
  logic        h_vis_d;
  logic        v_vis_d;
  logic        hs_in_d;
  logic        vs_in_d;

  assign div_last = (div_q == DIV_LAST);
  assign h_last   = (hloc_q == H_LAST);
  assign v_last   = (vloc_q == V_LAST);

  // Next state of the FSM, divider and raster counters.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    hloc_d  = hloc_q;
    vloc_d  = vloc_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
          div_d   = '0;
          hloc_d  = '0;
          vloc_d  = '0;
        end
      end
      ST_RUN, ST_STOP: begin
        state_d = run ? ST_RUN : ST_STOP;
        if (div_last) begin
          div_d = '0;
          if (h_last) begin
            hloc_d = '0;
            if (v_last) begin
              vloc_d = '0;
              // A pending stop only takes effect at the frame boundary;
              // a re-raised run on that same edge wraps as normal.
              if ((state_q == ST_STOP) && !run) begin
                state_d = ST_IDLE;
              end
            end else begin
              vloc_d = vloc_q + CW'(1);
            end
          end else begin
            hloc_d = hloc_q + CW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        hloc_d  = '0;
        vloc_d  = '0;
      end
    endcase
  end

  // Output flags decoded from the next-count values so they land with them.
  always_comb begin
    active_d      = (state_d != ST_IDLE);
    hx_d          = {1'b0, hloc_d};
    vx_d          = {1'b0, vloc_d};
    h_vis_d       = (hx_d < H_ACT_X);
    v_vis_d       = (vx_d < V_ACT_X);
    hs_in_d       = (hx_d >= HS_BEG_X) && (hx_d < HS_END_X);
    vs_in_d       = (vx_d >= VS_BEG_X) && (vx_d < VS_END_X);
    pix_ce_d      = active_d && (div_d == DIV_LAST);
    hsync_d       = (active_d && hs_in_d) ? HS_POL : ~HS_POL;
    vsync_d       = (active_d && vs_in_d) ? VS_POL : ~VS_POL;
    hblank_d      = !active_d || !h_vis_d;
    vblank_d      = !active_d || !v_vis_d;
    enable_d      = active_d && h_vis_d && v_vis_d;
    line_start_d  = active_d && (div_d == '0) && (hloc_d == '0);
    frame_start_d = line_start_d && (vloc_d == '0);
  end

  // FSM, counters and registered outputs; reset parks everything in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      hloc_q        <= '0;
      vloc_q        <= '0;
      pix_ce_q      <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      enable_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      hloc_q        <= hloc_d;
      vloc_q        <= vloc_d;
      pix_ce_q      <= pix_ce_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      enable_q      <= enable_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign enable      = enable_q;
  assign hloc        = hloc_q;
  assign vloc        = vloc_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign dbg_state   = state_q;

`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] frame_cnt_q;

  // Count frames; the count already includes the frame whose start is shown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Fully parametrised successor to the fixed 640x480 VGA timing core.
- Supplies the following to the PDP-8 video/terminal path:
  - horizontal/vertical sync
  - blanking flags
  - display enable
  - pixel coordinates
  - line/frame strobes
- Adds over the fixed core:
  - per-mode porch/sync/polarity parameters
  - integer pixel-clock divider
  - run/stop control that always finishes the current frame before parking
- All logic, including the vertical counter, runs single-clock synchronous; no derived clocks.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hsync
VS_POL, 0, asserted level of vsync
CLK_DIV, 1, clock cycles per pixel (>=1)
CW, 11, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
run  input  1  1 = generate timing; 0 = stop at end of current frame
pix_ce  output  1  pixel clock enable, one clock wide
hsync  output  1  horizontal sync, polarity HS_POL
vsync  output  1  vertical sync, polarity VS_POL
hblank  output  1  1 when hloc >= H_ACTIVE or idle
vblank  output  1  1 when vloc >= V_ACTIVE or idle
enable  output  1  1 when hloc < H_ACTIVE and vloc < V_ACTIVE and running
hloc  output  CW  current pixel column
vloc  output  CW  current line
line_start  output  1  one-clock pulse, first clock of column 0
frame_start  output  1  one-clock pulse, first clock of (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 default).
- Elaboration error if CW is too narrow or CLK_DIV < 1.
- Reset (asynchronous, immediate):
  - state IDLE
  - hloc = vloc = 0; divider = 0
  - pix_ce = 0, line_start = 0, frame_start = 0, enable = 0
  - hblank = vblank = 1
  - hsync = ~HS_POL, vsync = ~VS_POL
- Every output is registered. In RUN/STOP, all flags are coherent with the hloc/vloc values on the same clock, because flags are computed from the next-count values.
- Divider:
  - counts 0..CLK_DIV-1 while in RUN/STOP.
  - pix_ce = 1 on the clock where the divider equals CLK_DIV-1.
  - CLK_DIV = 1 gives pix_ce = 1 on every running clock.
- Counters advance only on pix_ce:
  - hloc increments; hloc == H_TOTAL-1 wraps to 0 and increments vloc.
  - vloc == V_TOTAL-1 on the same wrap goes to 0.
- hsync asserted iff H_ACTIVE+H_FP <= hloc < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted iff V_ACTIVE+V_FP <= vloc < V_ACTIVE+V_FP+V_SYNC. It changes only together with the vloc change, at the start of a line.
- line_start / frame_start:
  - high for exactly one clock: the first clock on which the new hloc=0 (or hloc=0 and vloc=0) is presented.
  - with CLK_DIV > 1 this is not the entire pixel duration.
- FSM:
  - IDLE: outputs held at reset values. run=1 sampled -> RUN. The next clock presents (0,0) with enable=1 (given H_ACTIVE, V_ACTIVE > 0), line_start=1, frame_start=1, and divider=0.
  - RUN: normal generation. run=0 -> STOP; counting is not interrupted.
  - STOP: normal generation continues.
    - run=1 -> RUN with no glitch.
    - On the pix_ce at (H_TOTAL-1, V_TOTAL-1) -> IDLE instead of wrapping; outputs return to reset values on the next clock.
  - Simultaneous last-pixel and run=1 in STOP: go to RUN and wrap normally (frame_start fires).
- reset asserted mid-frame overrides everything. After release the block waits in IDLE for run.

Optional Feature:
- Macro: VGA_TIMING_FRAMECNT_EN.
- Defined:
  - adds output frame_cnt [15:0], reset 0.
  - increments on every frame_start pulse; 16'hFFFF wraps to 0.
  - holds its value through IDLE; cleared only by reset.
- Undefined: no frame_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Defaults, CLK_DIV=1, run=1 after reset:
  - frame_start period 420000 clocks; line_start period 800 clocks.
  - hsync=0 exactly for hloc 656..751 (96 clocks).
  - enable high for 640 clocks per line on lines 0..479.
- Defaults, vertical:
  - vsync=0 exactly on vloc 490..491.
  - vblank=1 for vloc 480..524.
  - vsync and vloc change on the same clock.
- CLK_DIV=3: pix_ce pattern 0,0,1 repeating; line period 2400 clocks; line_start one clock wide.
- Stop/restart:
  - run dropped at vloc=100 -> generation continues to (799,524), then IDLE: enable=0, hblank=vblank=1, hsync=vsync=1.
  - Second run: run dropped, then re-raised at vloc=300 -> no interruption; next frame_start at the normal time.
- Async reset asserted at hloc=700, vloc=200:
  - all outputs take reset values the same cycle, without a clock edge.
  - after release with run=1, the first running clock shows (0,0) with frame_start=1.
- Small mode H 8/2/3/2, V 4/1/1/1, HS_POL=1, VS_POL=1, VGA_TIMING_FRAMECNT_EN defined:
  - hsync=1 for hloc 10..12; vsync=1 on vloc 5.
  - H_TOTAL=15, V_TOTAL=7.
  - frame_cnt=3 after 3 frame_start pulses.
